// File: rtl/sseg_pkg.sv
// sseg_pkg: segment patterns and BCD-to-7-segment decode shared by the scan driver
package sseg_pkg;

   typedef logic [6:0] seg_t;

   localparam int PHASES = 16;

   // Active-high patterns, bit6..bit0 = g,f,e,d,c,b,a
   localparam seg_t SEG_0     = 7'h3F;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;
   localparam seg_t SEG_7     = 7'h07;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h6F;
   localparam seg_t SEG_DASH  = 7'h40;
   localparam seg_t SEG_BLANK = 7'h00;

   // Non-decimal codes show a dash so a bad upstream value is visible on the display
   function automatic seg_t bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/scan_timebase.sv
// scan_timebase: prescaler, 16-step PWM phase and digit slot counter for the scan driver
module scan_timebase
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int L          = 100_000,
   parameter bit SIMULATE   = 1'b0,
   parameter int IW         = $clog2(NUM_DIGITS)
) (
   input  logic          clk,
   input  logic          reset,
   output logic [3:0]    phase_o,
   output logic [IW-1:0] digit_idx_o,
   output logic          frame_start_o
);

   localparam int SLOT     = SIMULATE ? PHASES : L;
   localparam int PRESCALE = SLOT / PHASES;
   localparam int PW       = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    phase_q, phase_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          tick, slot_end;

   // Prescaler wrap steps the phase; phase 15->0 closes the slot and moves to the next digit
   always_comb begin
      tick     = pre_q == PW'(PRESCALE - 1);
      slot_end = tick && phase_q == 4'd15;
      pre_d    = tick ? '0 : pre_q + 1'b1;
      phase_d  = tick ? phase_q + 4'd1 : phase_q;
      idx_d    = !slot_end ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
   end

   // Counter state with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_q   <= '0;
         phase_q <= '0;
         idx_q   <= '0;
      end else begin
         pre_q   <= pre_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
      end
   end

   assign phase_o       = phase_q;
   assign digit_idx_o   = idx_q;
   // All-zero counters mark the first cycle of a frame, including the first cycle out of reset
   assign frame_start_o = reset && pre_q == '0 && phase_q == 4'd0 && idx_q == '0;

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: multiplexed 7-segment driver with blanking, PWM dimming and frame capture
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS        = 4,
   parameter int CLK_INPUT_FREQ_HZ = 100_000_000,
   parameter int SCAN_FREQ_HZ      = 1000,
   parameter bit SEG_POLARITY      = 1'b1,
   parameter bit AN_POLARITY       = 1'b1,
   parameter bit SIMULATE          = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic [3:0]              brightness,
   input  logic                    enable,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic [6:0]              sseg_out,
   output logic                    dp_out,
   output logic                    frame_done
);

   localparam int L  = CLK_INPUT_FREQ_HZ / SCAN_FREQ_HZ;
   localparam int IW = $clog2(NUM_DIGITS);

   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_POLARITY}};
   localparam seg_t                  SEG_OFF = {7{SEG_POLARITY}};

   logic [3:0]    phase;
   logic [IW-1:0] digit_idx;
   logic          frame_start;

   logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]      dp_q, dp_d;
   logic                       blz_q, blz_d;
   logic [NUM_DIGITS-1:0]      zero_above;
   logic [NUM_DIGITS-1:0]      act;
   logic                       cur_blank;
   seg_t                       pat;

   logic [NUM_DIGITS-1:0] an_q, an_d;
   seg_t                  seg_q, seg_d;
   logic                  dpo_q, dpo_d;
   logic                  fd_q;

   scan_timebase #(
      .NUM_DIGITS (NUM_DIGITS),
      .L          (L),
      .SIMULATE   (SIMULATE),
      .IW         (IW)
   ) u_timebase (
      .clk           (clk),
      .reset         (reset),
      .phase_o       (phase),
      .digit_idx_o   (digit_idx),
      .frame_start_o (frame_start)
   );

   // Shadow bypass on frame start so the first slot of a frame already shows the new capture
   always_comb begin
      bcd_d = frame_start ? bcd_in : bcd_q;
      dp_d  = frame_start ? dp_in : dp_q;
      blz_d = frame_start ? blank_lz : blz_q;
   end

   // zero_above[k] is set when shadow digits k..NUM_DIGITS-1 are all zero
   always_comb begin
      zero_above = '0;
      zero_above[NUM_DIGITS-1] = bcd_d[NUM_DIGITS-1] == 4'd0;
      for (int k = NUM_DIGITS - 2; k >= 0; k--)
         zero_above[k] = zero_above[k+1] && bcd_d[k] == 4'd0;
   end

   // Select, blank and decode the current digit, then gate its anode with the PWM window
   always_comb begin
      cur_blank = blz_d && digit_idx != '0 && zero_above[digit_idx];
      pat       = cur_blank ? SEG_BLANK : bcd_to_seg(bcd_d[digit_idx]);
      act       = (enable && phase < brightness) ? NUM_DIGITS'(1) << digit_idx : '0;
      an_d      = act ^ AN_OFF;
      seg_d     = pat ^ SEG_OFF;
      dpo_d     = (!cur_blank && dp_d[digit_idx]) ^ SEG_POLARITY;
   end

   // Shadow capture and registered outputs so anode and segments switch on the same edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         bcd_q <= '0;
         dp_q  <= '0;
         blz_q <= 1'b0;
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dpo_q <= SEG_POLARITY;
         fd_q  <= 1'b0;
      end else begin
         bcd_q <= bcd_d;
         dp_q  <= dp_d;
         blz_q <= blz_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dpo_q <= dpo_d;
         fd_q  <= frame_start;
      end
   end

   assign an_out     = an_q;
   assign sseg_out   = seg_q;
   assign dp_out     = dpo_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: scoreboard bench driving directed frames and checking every output cycle
module tb_sseg_scan_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic        enable;
  logic [3:0]  an_out;
  logic [6:0]  sseg_out;
  logic        dp_out;
  logic        frame_done;
  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  localparam logic [6:0] OFF = 7'b1111111;
  sseg_scan_driver #(
    .NUM_DIGITS   (4),
    .SEG_POLARITY (1'b1),
    .AN_POLARITY  (1'b1),
    .SIMULATE     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .enable     (enable),
    .an_out     (an_out),
    .sseg_out   (sseg_out),
    .dp_out     (dp_out),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      if (mon_e.cyc != cyc || an_out !== mon_e.an || sseg_out !== mon_e.seg ||
          dp_out !== mon_e.dp || frame_done !== mon_e.fd) begin
        miscompares++;
        $display("FAIL %s cyc=%0d due=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 mon_e.tag, cyc, mon_e.cyc, an_out, sseg_out, dp_out, frame_done,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
      end
    end
  end
  task automatic push_rst(input int c, input string tag);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.an  = 4'b1111;
    e.seg = OFF;
    e.dp  = 1'b1;
    e.fd  = 1'b0;
    sb.push_back(e);
  endtask
  task automatic frame(input string tag, input logic [15:0] bcd, input logic [3:0] dp,
                       input logic blz, input logic [3:0] br, input logic en,
                       input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic [3:0] dpo, input int ncyc,
                       input int chg_at, input logic [15:0] chg_bcd);
    logic [6:0] st [4];
    exp_t e;
    st = '{s0, s1, s2, s3};
    bcd_in     = bcd;
    dp_in      = dp;
    blank_lz   = blz;
    brightness = br;
    enable     = en;
    for (int n = 0; n < ncyc; n++) begin
      int s, ph;
      s     = (n / 16) % 4;
      ph    = n % 16;
      e.cyc = cyc + 1 + n;
      e.tag = tag;
      e.an  = (en && ph < int'(br)) ? ~(4'b0001 << s) : 4'b1111;
      e.seg = st[s];
      e.dp  = dpo[s];
      e.fd  = (n % 64) == 0;
      sb.push_back(e);
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i == chg_at) bcd_in = chg_bcd;
      @(negedge clk);
    end
  endtask
  initial begin
    reset      = 1'b0;
    bcd_in     = 16'h0042;
    dp_in      = 4'b0000;
    blank_lz   = 1'b1;
    brightness = 4'd15;
    enable     = 1'b1;
    for (int c = 1; c <= 3; c++) push_rst(c, "reset");
    repeat (3) @(negedge clk);
    if (an_out !== 4'b1111 || sseg_out !== OFF || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state an=%b seg=%b dp=%b fd=%b", an_out, sseg_out, dp_out, frame_done);
    end
    reset = 1'b1;
    frame("lz_42", 16'h0042, 4'h0, 1'b1, 4'd15, 1'b1,
          7'b0100100, 7'b0011001, OFF, OFF, 4'b1111, 64, -1, 16'h0);
    frame("lz_0000", 16'h0000, 4'h0, 1'b1, 4'd15, 1'b1,
          7'b1000000, OFF, OFF, OFF, 4'b1111, 64, -1, 16'h0);
    frame("nolz_0000", 16'h0000, 4'h0, 1'b0, 4'd15, 1'b1,
          7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 64, -1, 16'h0);
    frame("dash_a7", 16'h00A7, 4'b0010, 1'b1, 4'd15, 1'b1,
          7'b1111000, 7'b0111111, OFF, OFF, 4'b1101, 64, -1, 16'h0);
    frame("bright4_1234", 16'h1234, 4'b1111, 1'b0, 4'd4, 1'b1,
          7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b0000, 64, -1, 16'h0);
    frame("bright0", 16'h0042, 4'h0, 1'b1, 4'd0, 1'b1,
          7'b0100100, 7'b0011001, OFF, OFF, 4'b1111, 64, -1, 16'h0);
    frame("enable0", 16'h0042, 4'h0, 1'b1, 4'd15, 1'b0,
          7'b0100100, 7'b0011001, OFF, OFF, 4'b1111, 64, -1, 16'h0);
    frame("hold_12", 16'h0012, 4'h0, 1'b1, 4'd15, 1'b1,
          7'b0100100, 7'b1111001, OFF, OFF, 4'b1111, 64, 20, 16'h0099);
    frame("new_99", 16'h0099, 4'h0, 1'b1, 4'd15, 1'b1,
          7'b0010000, 7'b0010000, OFF, OFF, 4'b1111, 64, -1, 16'h0);
    frame("pre_rst", 16'h0042, 4'h0, 1'b1, 4'd15, 1'b1,
          7'b0100100, 7'b0011001, OFF, OFF, 4'b1111, 21, -1, 16'h0);
    reset = 1'b0;
    push_rst(cyc + 1, "mid_reset");
    push_rst(cyc + 2, "mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    frame("post_rst", 16'h0000, 4'h0, 1'b0, 4'd15, 1'b1,
          7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 64, -1, 16'h0);
    repeat (2) @(negedge clk);
    if (sb.size() != 0 || vectors == 0) begin
      miscompares++;
      $display("FAIL expired_wait %0d expectations never checked, %0d vectors", sb.size(), vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Downstream display stage for the two-digit scoreboard.
- Takes packed BCD digits and decimal points and time-multiplexes them onto a common-segment 7-segment display: one-hot digit anodes plus a shared segment bus.
- Provides leading-zero blanking, invalid-digit indication, 16-level brightness PWM and tear-free frame capture.
- Runs on the 100 MHz board clock.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- CLK_INPUT_FREQ_HZ, 100_000_000: input clock frequency.
- SCAN_FREQ_HZ, 1000: digit-slot rate. Slot length L = CLK_INPUT_FREQ_HZ/SCAN_FREQ_HZ and must be a multiple of 16.
- SEG_POLARITY, 1: 1 = segments/dp active-low, 0 = active-high.
- AN_POLARITY, 1: 1 = anodes active-low, 0 = active-high.
- SIMULATE, 0: 1 forces L = 16 clocks (prescale 1) for simulation.

Ports:
- clk  in  1  board clock.
- reset  in  1  synchronous, active-low reset.
- bcd_in  in  4*NUM_DIGITS  packed BCD, digit 0 = bits [3:0] = least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_lz  in  1  1 = blank leading zeros.
- brightness  in  4  on-time in 16ths of a slot (0 = dark).
- enable  in  1  0 = all anodes inactive.
- an_out  out  NUM_DIGITS  digit anodes, one-hot when active, per AN_POLARITY.
- sseg_out  out  7  segments, bit6..bit0 = g,f,e,d,c,b,a, per SEG_POLARITY.
- dp_out  out  1  decimal point, per SEG_POLARITY.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (reset==0 sampled on posedge clk):
  - All counters, digit_idx and the shadow register clear to 0.
  - an_out = all inactive; sseg_out = all segments off; dp_out = off; frame_done = 0.
  - Reset asserted mid-scan takes effect on the next edge.
- Timebase:
  - Prescaler counts 0..L/16-1; each wrap advances phase (4-bit, 0..15).
  - phase wrapping 15->0 ends the slot and advances digit_idx.
  - digit_idx wraps NUM_DIGITS-1 -> 0.
- Frame capture:
  - On the cycle digit_idx wraps to 0 (and the first cycle after reset release), bcd_in/dp_in/blank_lz load into the shadow register.
  - frame_done pulses that same cycle.
  - Input changes mid-frame are not visible until the next frame.
- Leading-zero blanking (from shadow):
  - Digit k is blanked if blank_lz=1 and all shadow digits k..NUM_DIGITS-1 equal 0.
  - Digit 0 is never blanked.
  - A blanked digit has segments off and dp forced off.
- Decode:
  - Values 0-9 map to the standard patterns.
  - 10-15 display a dash (g only).
- PWM:
  - Anode k is active iff enable=1 && digit_idx==k && phase < brightness.
  - brightness is sampled live, not shadowed.
  - brightness 0 gives all anodes off; 15 gives 15/16 duty. The guaranteed off phase 15 acts as the anti-ghosting gap.
- Latency: an_out, sseg_out and dp_out are all registered, exactly 1 clock after the internal state that selects them. Segments and anode switch on the same edge.
- enable=0: anodes inactive; timebase, capture and frame_done continue.
- Segment/dp outputs still drive the decoded value while the anode is off (don't-care electrically, but deterministic for the bench).

Decomposition:
- Package sseg_pkg:
  - 7-bit pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-high form).
  - Function bcd_to_seg (4-bit -> 7-bit).
  - Polarity applied at the output.
- Sub-module scan_timebase:
  - Contents: prescaler, phase counter, digit_idx counter.
  - Outputs: phase, digit_idx, frame_start.
  - Parameters: NUM_DIGITS, L, SIMULATE.

Test Plan:
- SIMULATE=1, NUM_DIGITS=4, polarities 1, reset held 3 clocks -> an_out=4'b1111, sseg_out=7'b1111111, dp_out=1, frame_done=0 throughout reset.
- bcd_in=16'h0042, blank_lz=1, brightness=15, enable=1:
  - Slot 0 shows 2 (sseg_out=7'b0100100), slot 1 shows 4 (7'b0011001).
  - Slots 2-3 have segments off.
  - an_out active 15 of 16 clocks per slot; frame_done pulses every 64 clocks.
- bcd_in=16'h0000, blank_lz=1 -> only digit 0 shows 0 (7'b1000000); digits 1-3 blank. With blank_lz=0, all four show 0.
- bcd_in=16'h00A7, dp_in=4'b0010 -> digit 1 shows a dash (7'b0111111) with dp_out=0; digit 0 shows 7.
- brightness=4 -> each anode is active for exactly 4 consecutive clocks per slot. brightness=0 or enable=0 -> an_out stays 4'b1111 while frame_done keeps pulsing.
- Change bcd_in from 16'h0012 to 16'h0099 during slot 1 -> remaining slots of the current frame still show 12; the next frame (after frame_done) shows 99. Reset mid-slot -> the next cycle returns to the reset values.
